// File: rtl/matmul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : matmul_sequencer
// Description : Control sequencer for an external 2x2 matrix-multiply
//               datapath. Accepts eight 8-bit operands on a valid/ready
//               stream (A00,A01,A10,A11,B00,B01,B10,B11) and writes them
//               into the datapath. It then lets the multiply settle and
//               reads the four 17-bit results back out on a second
//               valid/ready stream (C00,C01,C10,C11).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SETTLE_CYCLES : execute-high cycles allowed before the first result read
//                   (legal range 1..15, held in a 4-bit counter)
// Ports
//   wb_clk_i      in   1   clock, all state changes on its rising edge
//   wb_rst_i      in   1   synchronous active-high reset
//   abort         in   1   synchronous request to discard the current job
//   in_valid      in   1   operand stream valid
//   in_data       in   8   operand value
//   in_ready      out  1   operand stream ready (LOAD only)
//   out_valid     out  1   result stream valid (PRESENT only)
//   out_data      out 17   result value
//   out_last      out  1   marks C11, the final result of a job
//   out_ready     in   1   result stream ready
//   busy          out  1   a job is past the operand-load phase
//   done          out  1   one-cycle pulse after the final result handshake
//   mm_reset_n    out  1   datapath clear, active low
//   mm_execute    out  1   datapath multiply enable (operand writes when 0)
//   mm_sel_in     out  3   datapath operand write index
//   mm_input_val  out  8   datapath operand write value
//   mm_sel_out    out  2   datapath result read index
//   mm_result     in  17   datapath result for mm_sel_out
// ============================================================================
module matmul_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        abort,
  // operand stream
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  // result stream
  output logic        out_valid,
  output logic [16:0] out_data,
  output logic        out_last,
  input  logic        out_ready,
  // status
  output logic        busy,
  output logic        done,
  // datapath control
  output logic        mm_reset_n,
  output logic        mm_execute,
  output logic [2:0]  mm_sel_in,
  output logic [7:0]  mm_input_val,
  output logic [1:0]  mm_sel_out,
  input  logic [16:0] mm_result
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [3:0] C_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] C_IN_LAST     = 3'd7;
  localparam logic [1:0] C_OUT_LAST    = 2'd3;

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_CLEAR   = 3'd0,  // datapath held in reset for one cycle
    S_LOAD    = 3'd1,  // accepting operands
    S_COMMIT  = 3'd2,  // execute still low so operand 7 lands
    S_SETTLE  = 3'd3,  // execute high, waiting for the multiply
    S_FETCH   = 3'd4,  // mm_sel_out stable, result captured at the edge
    S_PRESENT = 3'd5   // result offered on the output stream
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [2:0]  r_in_idx;
  logic [1:0]  r_out_idx;
  logic [3:0]  r_settle_cnt;
  logic [2:0]  r_sel_in;
  logic [7:0]  r_input_val;
  logic [1:0]  r_sel_out;
  logic [16:0] r_out_data;
  logic        r_done;

  logic        w_run;
  logic        w_in_hs;
  logic        w_out_hs;
  logic        w_settle_end;

  // Combinational outputs are forced to their idle values while reset is
  // asserted so the block looks quiescent from the very first reset cycle,
  // not only after the first reset edge.
  assign w_run = ~wb_rst_i;

  // Abort wins over any handshake presented in the same cycle, so the
  // handshakes themselves are qualified with ~abort.
  assign w_in_hs      = (r_state == S_LOAD) && in_valid && ~abort && w_run;
  assign w_out_hs     = (r_state == S_PRESENT) && out_ready && ~abort && w_run;
  assign w_settle_end = (r_settle_cnt == C_SETTLE_LAST);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: begin
        w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (w_in_hs && (r_in_idx == C_IN_LAST)) begin
          w_state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (w_settle_end) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        w_state_nxt = S_PRESENT;
      end
      S_PRESENT: begin
        if (w_out_hs) begin
          w_state_nxt = (r_out_idx == C_OUT_LAST) ? S_CLEAR : S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_CLEAR;
      end
    endcase

    if (abort) begin
      w_state_nxt = S_CLEAR;
    end
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= S_CLEAR;
      r_in_idx     <= 3'd0;
      r_out_idx    <= 2'd0;
      r_settle_cnt <= 4'd0;
      r_sel_in     <= 3'd0;
      r_input_val  <= 8'd0;
      r_sel_out    <= 2'd0;
      r_out_data   <= 17'd0;
      r_done       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;

      if (abort) begin
        // Operand/result registers toward the datapath are left alone; the
        // CLEAR cycle wipes the datapath and the counters restart at zero.
        r_in_idx     <= 3'd0;
        r_out_idx    <= 2'd0;
        r_settle_cnt <= 4'd0;
        r_sel_out    <= 2'd0;
      end else begin
        // Operand capture. The 3-bit index wraps to 0 after operand 7.
        if (w_in_hs) begin
          r_sel_in    <= r_in_idx;
          r_input_val <= in_data;
          r_in_idx    <= r_in_idx + 3'd1;
        end

        if (r_state == S_SETTLE) begin
          r_settle_cnt <= w_settle_end ? 4'd0 : (r_settle_cnt + 4'd1);
        end

        // mm_sel_out has been stable for the whole FETCH cycle here.
        if (r_state == S_FETCH) begin
          r_out_data <= mm_result;
        end

        // Result index and read select advance together; both wrap to 0
        // after C11 so the next job starts reading at C00.
        if (w_out_hs) begin
          r_out_idx <= r_out_idx + 2'd1;
          r_sel_out <= r_out_idx + 2'd1;
          r_done    <= (r_out_idx == C_OUT_LAST);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready     = w_run && (r_state == S_LOAD);
  assign out_valid    = w_run && (r_state == S_PRESENT);
  assign out_last     = w_run && (r_state == S_PRESENT) && (r_out_idx == C_OUT_LAST);
  assign out_data     = r_out_data;
  assign busy         = w_run && (r_state != S_CLEAR) && (r_state != S_LOAD);
  assign done         = w_run && r_done;

  assign mm_reset_n   = w_run && (r_state != S_CLEAR);
  assign mm_execute   = w_run && ((r_state == S_SETTLE) ||
                                  (r_state == S_FETCH)  ||
                                  (r_state == S_PRESENT));
  assign mm_sel_in    = r_sel_in;
  assign mm_input_val = r_input_val;
  assign mm_sel_out   = r_sel_out;

endmodule
`default_nettype wire

// File: tb/tb_matmul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_sequencer
// Description : Self-checking bench for matmul_sequencer. Includes a model of
//               the external 2x2 multiply datapath and a matrix-arithmetic
//               reference for expected results.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_matmul_sequencer;

  localparam int S = 2;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        abort;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [16:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        mm_reset_n;
  logic        mm_execute;
  logic [2:0]  mm_sel_in;
  logic [7:0]  mm_input_val;
  logic [1:0]  mm_sel_out;
  logic [16:0] mm_result;

  matmul_sequencer #(.SETTLE_CYCLES(S)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .abort       (abort),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done),
    .mm_reset_n  (mm_reset_n),
    .mm_execute  (mm_execute),
    .mm_sel_in   (mm_sel_in),
    .mm_input_val(mm_input_val),
    .mm_sel_out  (mm_sel_out),
    .mm_result   (mm_result)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  int cyc = 0;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  // --------------------------------------------------------------------------
  // External datapath: operand register file written while execute is low,
  // cleared while reset_n is low; result is garbage unless executing.
  // --------------------------------------------------------------------------
  logic [7:0] dp_reg [8];
  int         dp_c;

  always @(posedge wb_clk_i) begin
    if (!mm_reset_n) begin
      for (int i = 0; i < 8; i++) dp_reg[i] <= 8'd0;
    end else if (!mm_execute) begin
      dp_reg[mm_sel_in] <= mm_input_val;
    end
  end

  always_comb begin
    dp_c = int'(dp_reg[{1'b0, mm_sel_out[1], 1'b0}]) * int'(dp_reg[{2'b10, mm_sel_out[0]}])
         + int'(dp_reg[{1'b0, mm_sel_out[1], 1'b1}]) * int'(dp_reg[{2'b11, mm_sel_out[0]}]);
    mm_result = mm_execute ? dp_c[16:0] : 17'h1FFFF;
  end

  // --------------------------------------------------------------------------
  // Checking infrastructure
  // --------------------------------------------------------------------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  // Reference: C = A * B with A, B the two 2x2 matrices in row-major order.
  function automatic logic [3:0][16:0] matmul_ref(input logic [7:0][7:0] ops);
    int a [2][2];
    int b [2][2];
    logic [3:0][16:0] c;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 2; k++) begin
        a[r][k] = int'(ops[2*r + k]);
        b[r][k] = int'(ops[4 + 2*r + k]);
      end
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < 2; q++)
        c[2*r + q] = 17'(a[r][0] * b[0][q] + a[r][1] * b[1][q]);
    return c;
  endfunction

  function automatic logic [7:0][7:0] mk8(input int v0, v1, v2, v3, v4, v5, v6, v7);
    logic [7:0][7:0] o;
    o[0] = 8'(v0); o[1] = 8'(v1); o[2] = 8'(v2); o[3] = 8'(v3);
    o[4] = 8'(v4); o[5] = 8'(v5); o[6] = 8'(v6); o[7] = 8'(v7);
    return o;
  endfunction

  function automatic logic [3:0][16:0] mk4(input int c0, c1, c2, c3);
    logic [3:0][16:0] o;
    o[0] = 17'(c0); o[1] = 17'(c1); o[2] = 17'(c2); o[3] = 17'(c3);
    return o;
  endfunction

  typedef struct {
    logic [7:0][7:0]  ops;
    logic [3:0][16:0] exp;
  } vec_t;

  // Sends n operands; in_valid stays high afterwards when hold is set.
  task automatic send_ops(input logic [7:0][7:0] ops, input int n, input bit hold,
                          output int hs_cyc);
    hs_cyc = cyc;
    for (int k = 0; k < n; k++) begin
      int b = 0;
      in_valid = 1'b1;
      in_data  = ops[k];
      while (!in_ready && b < 50) begin step(); b++; end
      if (!in_ready) begin
        chk("send_timeout", 32'(k), 32'(n));
        in_valid = 1'b0;
        return;
      end
      step();
      hs_cyc = cyc;
    end
    if (!hold) in_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: ready after 5 stalled cycles, 2: random ready.
  task automatic recv_job(input logic [3:0][16:0] exp, input int hs_cyc,
                          input int mode, input bit hold_in);
    int k = 0, budget = 0, stall = 0, inrdy_bad = 0;
    bit first = 1'b1, newres = 1'b1, fire;
    logic [16:0] held_d;
    logic        held_l;
    held_d    = '0;
    held_l    = 1'b0;
    out_ready = 1'b0;
    while (k < 4 && budget < 400) begin
      if (hold_in) begin
        in_data = 8'($urandom);
        if (in_ready) inrdy_bad++;
      end
      if (out_valid) begin
        if (first) begin
          chk("latency", 32'(cyc - hs_cyc), 32'(S + 2));
          first = 1'b0;
        end
        if (newres) begin
          chk("c_data", 32'(out_data), 32'(exp[k]));
          chk("c_last", 32'(out_last), 32'(k == 3));
          chk("c_busy_exec", {30'd0, busy, mm_execute}, 32'd3);
          held_d = out_data;
          held_l = out_last;
          newres = 1'b0;
          stall  = 0;
        end else begin
          chk("stall_stable", {14'd0, held_l, held_d}, {14'd0, out_last, out_data});
        end
        case (mode)
          0:       out_ready = 1'b1;
          1:       out_ready = (stall >= 5);
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        stall++;
      end else begin
        out_ready = 1'b0;
      end
      fire = out_valid && out_ready;
      step();
      budget++;
      if (fire) begin
        k++;
        newres = 1'b1;
      end
    end
    out_ready = 1'b0;
    if (hold_in) begin
      in_valid = 1'b0;
      chk("no_extra_operands", 32'(inrdy_bad), 32'd0);
    end
    if (k < 4) begin
      chk("recv_timeout", 32'(k), 32'd4);
    end else begin
      chk("done_pulse", {29'd0, done, out_valid, mm_reset_n}, 32'b100);
      step();
      chk("done_clear_load", {30'd0, done, in_ready}, 32'b01);
    end
  endtask

  task automatic wait_valid();
    int b = 0;
    while (!out_valid && b < 50) begin step(); b++; end
    if (!out_valid) chk("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_vals(input string name);
    chk(name, {16'd0, in_ready, out_valid, out_last, busy, done, mm_execute, mm_reset_n,
               mm_sel_in, mm_input_val[0], mm_sel_out, 2'd0},
        32'd0);
    chk({name, "_data"}, {7'd0, out_data, mm_input_val}, 32'd0);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  vec_t vecs [4];

  initial begin
    int hs;
    logic [7:0][7:0] rops;

    vecs[0].ops = mk8(1, 2, 3, 4, 5, 6, 7, 8);         vecs[0].exp = mk4(19, 22, 43, 50);
    vecs[1].ops = mk8(255, 255, 255, 255, 255, 255, 255, 255);
    vecs[1].exp = mk4(130050, 130050, 130050, 130050);
    vecs[2].ops = mk8(2, 0, 0, 2, 3, 4, 5, 6);         vecs[2].exp = mk4(6, 8, 10, 12);
    vecs[3].ops = mk8(1, 0, 0, 1, 10, 20, 30, 40);     vecs[3].exp = mk4(10, 20, 30, 40);

    wb_rst_i = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    step(); step();
    check_reset_vals("reset_state");
    wb_rst_i = 1'b0;
    chk("clear_after_reset", {30'd0, mm_reset_n, in_ready}, 32'd0);
    step();
    chk("load_after_clear", {30'd0, mm_reset_n, in_ready}, 32'b11);

    // Table-driven jobs, always-ready consumer.
    for (int v = 0; v < 4; v++) begin
      send_ops(vecs[v].ops, 8, 1'b0, hs);
      recv_job(vecs[v].exp, hs, 0, 1'b0);
    end

    // Consumer stalls 5 cycles on every result.
    send_ops(vecs[0].ops, 8, 1'b0, hs);
    recv_job(vecs[0].exp, hs, 1, 1'b0);

    // in_valid held high with changing data after the 8th operand.
    send_ops(vecs[0].ops, 8, 1'b1, hs);
    recv_job(vecs[0].exp, hs, 0, 1'b1);

    // Abort after 5 operands, same-cycle handshake discarded, abort in CLEAR.
    send_ops(mk8(9, 9, 9, 9, 9, 9, 9, 9), 5, 1'b0, hs);
    in_valid = 1'b1; in_data = 8'd77; abort = 1'b1;
    step();
    chk("abort_clear", {29'd0, in_ready, mm_reset_n, busy}, 32'd0);
    step();
    chk("abort_reclear", {30'd0, mm_reset_n, in_ready}, 32'd0);
    abort = 1'b0; in_valid = 1'b0;
    step();
    chk("abort_load", 32'(in_ready), 32'd1);
    send_ops(vecs[2].ops, 8, 1'b0, hs);
    recv_job(vecs[2].exp, hs, 0, 1'b0);

    // Reset while C01 is being presented.
    send_ops(vecs[0].ops, 8, 1'b0, hs);
    wait_valid();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    wait_valid();
    chk("c01_before_reset", 32'(out_data), 32'd22);
    wb_rst_i = 1'b1;
    #1;
    chk("reset_comb", {28'd0, in_ready, out_valid, busy, mm_reset_n}, 32'd0);
    step();
    check_reset_vals("midjob_reset");
    wb_rst_i = 1'b0;
    chk("midjob_clear", 32'(mm_reset_n), 32'd0);
    step();
    chk("midjob_load", 32'(in_ready), 32'd1);
    send_ops(vecs[0].ops, 8, 1'b0, hs);
    recv_job(vecs[0].exp, hs, 0, 1'b0);

    // Random jobs against the arithmetic reference, random back-pressure.
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 8; i++) rops[i] = 8'($urandom);
      send_ops(rops, 8, 1'b0, hs);
      recv_job(matmul_ref(rops), hs, 2, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning execute-high cycles allowed for the 2x2 multiply to settle before the first read (legal 1..15).
REQ-002 SHALL have port wb_clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port wb_rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port abort  input  1  synchronous request to discard the current job.
REQ-005 SHALL have ports in_valid input 1, in_data input 8, in_ready output 1  operand stream (valid/ready), order A00,A01,A10,A11,B00,B01,B10,B11.
REQ-006 SHALL have ports out_valid output 1, out_data output 17, out_last output 1, out_ready input 1  result stream, order C00,C01,C10,C11.
REQ-007 SHALL have ports busy output 1 (job past LOAD) and done output 1 (one-cycle pulse on final result handshake).
REQ-008 SHALL have datapath ports mm_reset_n output 1, mm_execute output 1, mm_sel_in output 3, mm_input_val output 8, mm_sel_out output 2, mm_result input 17.

Function
REQ-009 SHALL implement states CLEAR, LOAD, COMMIT, SETTLE, FETCH, PRESENT.
REQ-010 CLEAR: mm_reset_n=0 for exactly one cycle; then LOAD unconditionally.
REQ-011 mm_reset_n SHALL be 1 in all states except CLEAR.
REQ-012 mm_execute SHALL be 1 only in SETTLE, FETCH, PRESENT; it SHALL be 0 in CLEAR, LOAD, COMMIT.
REQ-013 LOAD: in_ready=1 (and 0 in every other state); each handshake registers mm_sel_in<=in_idx, mm_input_val<=in_data, in_idx increments.
REQ-014 mm_sel_in and mm_input_val SHALL hold their last value between handshakes (datapath rewrites the same value harmlessly).
REQ-015 8th handshake (in_idx=7) SHALL move to COMMIT, in_idx wraps to 0.
REQ-016 COMMIT: one cycle, execute held 0 so operand 7 is written; then SETTLE.
REQ-017 SETTLE: stay exactly SETTLE_CYCLES cycles (4-bit counter), then FETCH.
REQ-018 FETCH: mm_sel_out=out_idx stable one cycle; next edge out_data<=mm_result, state PRESENT.
REQ-019 PRESENT: out_valid=1, out_data stable until out_ready; out_last=1 iff out_idx=3.
REQ-020 Result handshake with out_idx<3: out_idx increments, mm_sel_out updated, return to FETCH.
REQ-021 Result handshake with out_idx=3: done=1 for that cycle's following edge only (one cycle), out_idx wraps to 0, go to CLEAR.
REQ-022 Latency: out_valid SHALL rise SETTLE_CYCLES+2 cycles after the edge of the 8th operand handshake (4 at default).
REQ-023 busy SHALL be 1 in COMMIT, SETTLE, FETCH, PRESENT; 0 in CLEAR, LOAD.
REQ-024 out_data SHALL be mm_result zero-extended unchanged (17 bits holds max 2*255*255=130050; no saturation).
REQ-025 abort=1 in any state SHALL go to CLEAR next edge, zero in_idx/out_idx/settle count, deassert out_valid; abort has priority over a same-cycle in/out handshake, which is discarded and done not pulsed.
REQ-026 abort during CLEAR SHALL re-enter CLEAR (mm_reset_n low one further cycle).
REQ-027 in_valid while in_ready=0 SHALL be ignored; in_data not sampled.

Reset
REQ-028 wb_rst_i=1 SHALL force state CLEAR at next edge, overriding abort and handshakes.
REQ-029 During/after reset: in_ready=0, out_valid=0, out_last=0, busy=0, done=0, mm_execute=0, mm_sel_in=0, mm_input_val=0, mm_sel_out=0, out_data=0, counters 0; mm_reset_n=0 while wb_rst_i=1 and for the CLEAR cycle after.
REQ-030 Reset mid-job SHALL discard all operands and results; first cycle after the CLEAR cycle is LOAD.

Verification
REQ-031 Operands 1,2,3,4,5,6,7,8, out_ready=1 -> outputs 19,22,43,50, out_last on 50, done one cycle, out_valid 4 cycles after 8th handshake.
REQ-032 All operands 255 -> four outputs 130050, no overflow.
REQ-033 Same job, out_ready low 5 cycles on each result -> out_data/out_last stable while stalled, same 19,22,43,50.
REQ-034 abort after 5 operands, then full job 2,0,0,2,3,4,5,6 -> outputs 6,8,10,12; no stale data.
REQ-035 wb_rst_i pulsed during PRESENT of C01 -> all outputs at reset values, mm_reset_n low, next job correct.
REQ-036 in_valid held high through COMMIT/SETTLE/PRESENT with changing in_data -> no extra operands accepted, results unchanged.
